// File: rtl/mux_pkg.sv
// Shared definitions for the N-to-1 selector slice.
//   MODE_EXT / MODE_SCAN : encodings of the mux_nto1_pipe 'mode' input.
//   RECIP_Q_1..RECIP_Q_4 : 1/n reciprocal constants in unsigned Q16.16.
//                          Integrators place these on in_data channels
//                          feeding the multiply/accumulate datapath.
package mux_pkg;

  localparam logic MODE_EXT  = 1'b0;
  localparam logic MODE_SCAN = 1'b1;

  localparam int RECIP_FRAC_BITS = 16;

  // 1/n rounded down in Q16.16
  localparam logic [31:0] RECIP_Q_1 = 32'h0001_0000;
  localparam logic [31:0] RECIP_Q_2 = 32'h0000_8000;
  localparam logic [31:0] RECIP_Q_3 = 32'h0000_5555;
  localparam logic [31:0] RECIP_Q_4 = 32'h0000_4000;

endpackage

// File: rtl/mux_out_reg.sv
// Single-stage valid/ready output register.
// Ports:
//   clk, rst_n   : clock and synchronous active-low reset
//   in_valid     : upstream beat valid
//   in_ready     : stage can take a beat (empty, or being drained this cycle)
//   in_payload   : word captured on an accepted beat
//   out_valid    : payload_reg holds a beat
//   out_ready    : downstream takes the beat
//   out_payload  : registered payload, stable while stalled
module mux_out_reg #(
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_payload,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] out_payload
);

  logic          valid_reg;
  logic [PW-1:0] payload_reg;
  logic          accept;

  // Refill in the same cycle the held beat leaves: full throughput with
  // only a combinational out_ready -> in_ready path.
  assign in_ready = !valid_reg || out_ready;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_reg   <= 1'b0;
      payload_reg <= '0;
    end else if (accept) begin
      valid_reg   <= 1'b1;
      payload_reg <= in_payload;
    end else if (out_ready) begin
      valid_reg   <= 1'b0;
    end
  end

  assign out_valid   = valid_reg;
  assign out_payload = payload_reg;

endmodule

// File: rtl/mux_nto1_pipe.sv
// Parametrised N-to-1 word selector with a registered valid/ready output and
// an auto-scan mode that steps through the channels one accepted beat at a time.
// Ports:
//   clk, rst_n          : clock and synchronous active-low reset
//   in_valid / in_ready : upstream handshake
//   mode                : MODE_EXT uses sel, MODE_SCAN uses the internal scan index
//   sel                 : external channel index
//   scan_clr            : zero the scan index at the next edge
//   in_data             : N packed channels, channel k = in_data[k*W +: W]
//   out_valid/out_ready : downstream handshake
//   out_data            : selected word (0 when the index was out of range)
//   out_sel             : index that produced out_data
//   sel_err             : index was >= N for this beat
module mux_nto1_pipe
  import mux_pkg::*;
#(
  parameter int N     = 4,
  parameter int W     = 32,
  parameter int SEL_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mode,
  input  logic [SEL_W-1:0] sel,
  input  logic             scan_clr,
  input  logic [N*W-1:0]   in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic [SEL_W-1:0] out_sel,
  output logic             sel_err
);

  localparam int               PW       = 1 + SEL_W + W;
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N - 1);
  // One extra bit so N == 2**SEL_W is still representable.
  localparam logic [SEL_W:0]   N_EXT    = (SEL_W + 1)'(N);

  logic [SEL_W-1:0] scan_idx_reg;
  logic [SEL_W-1:0] scan_idx_next;
  logic [SEL_W-1:0] eff_idx;
  logic             idx_err;
  logic             accept;
  logic [W-1:0]     masked [N];
  logic [W-1:0]     sel_word;
  logic [PW-1:0]    payload_in;
  logic [PW-1:0]    payload_out;

  assign eff_idx = (mode == MODE_SCAN) ? scan_idx_reg : sel;
  assign idx_err = ({1'b0, eff_idx} >= N_EXT);

  // AND-OR select: an out-of-range index matches no channel, so the
  // selected word is zero without a separate override.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_ch
      localparam logic [SEL_W-1:0] CH_IDX = SEL_W'(gi);
      assign masked[gi] = (eff_idx == CH_IDX) ? in_data[gi*W +: W] : '0;
    end
  endgenerate

  always_comb begin
    sel_word = '0;
    for (int k = 0; k < N; k++) begin
      sel_word = sel_word | masked[k];
    end
  end

  assign accept = in_valid && in_ready;

  // Clear has priority over advance; the colliding beat already used the
  // old index through eff_idx.
  always_comb begin
    scan_idx_next = scan_idx_reg;
    if (scan_clr) begin
      scan_idx_next = '0;
    end else if (accept && (mode == MODE_SCAN)) begin
      scan_idx_next = (scan_idx_reg == LAST_IDX) ? '0 : scan_idx_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan_idx_reg <= '0;
    end else begin
      scan_idx_reg <= scan_idx_next;
    end
  end

  assign payload_in = {idx_err, eff_idx, sel_word};

  mux_out_reg #(
    .PW(PW)
  ) u_out_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_payload (payload_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_payload(payload_out)
  );

  assign {sel_err, out_sel, out_data} = payload_out;

endmodule

// File: tb/tb_mux_nto1_pipe.sv
// Directed bench for mux_nto1_pipe (N=4, W=32, SEL_W=3).
module tb_mux_nto1_pipe;

  localparam int N     = 4;
  localparam int W     = 32;
  localparam int SEL_W = 3;

  localparam logic [31:0] CA = 32'hAAAA_0001;
  localparam logic [31:0] CB = 32'hBBBB_0002;
  localparam logic [31:0] CC = 32'hCCCC_0003;
  localparam logic [31:0] CD = 32'hDDDD_0004;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic             mode;
  logic [SEL_W-1:0] sel;
  logic             scan_clr;
  logic [N*W-1:0]   in_data;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_data;
  logic [SEL_W-1:0] out_sel;
  logic             sel_err;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_ch [4];

  mux_nto1_pipe #(
    .N(N), .W(W), .SEL_W(SEL_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .mode     (mode),
    .sel      (sel),
    .scan_clr (scan_clr),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_sel  (out_sel),
    .sel_err  (sel_err)
  );

  always #5 clk = ~clk;

  // Advance one edge; sample 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) begin
      $display("check %s observed=%0h expected=%0h ok", tag, obs, exp);
    end else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check a full output beat.
  task automatic chk_beat(input string tag, input logic [31:0] d,
                          input logic [SEL_W-1:0] s, input logic e);
    chk({tag, "_valid"}, out_valid, 1'b1);
    chk({tag, "_data"},  out_data,  d);
    chk({tag, "_sel"},   out_sel,   s);
    chk({tag, "_err"},   sel_err,   e);
  endtask

  initial begin
    exp_ch[0] = CA; exp_ch[1] = CB; exp_ch[2] = CC; exp_ch[3] = CD;

    // 1. Reset held 3 cycles with in_valid high
    rst_n = 1'b0; in_valid = 1'b1; mode = 1'b0; sel = 3'd2; scan_clr = 1'b0;
    out_ready = 1'b1; in_data = {CD, CC, CB, CA};
    tick(); tick(); tick();
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_data",  out_data,  32'h0);
    chk("rst_sel",   out_sel,   3'd0);
    chk("rst_err",   sel_err,   1'b0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("rel_in_ready", in_ready, 1'b1);
    chk("rel_valid", out_valid, 1'b0);

    // 2. External select, back-to-back
    in_valid = 1'b1; mode = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sel = SEL_W'(i);
      tick();
      chk_beat($sformatf("ext%0d", i), exp_ch[i], SEL_W'(i), 1'b0);
    end

    // 3. Out-of-range select, then recovery
    sel = 3'd4; tick();
    chk_beat("err4", 32'h0, 3'd4, 1'b1);
    sel = 3'd7; tick();
    chk_beat("err7", 32'h0, 3'd7, 1'b1);
    sel = 3'd1; tick();
    chk_beat("err_recover", CB, 3'd1, 1'b0);

    // 4. Scan wrap over 6 beats; sel is ignored in scan mode
    mode = 1'b1; sel = 3'd7;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_beat($sformatf("scan%0d", i), exp_ch[i % 4], SEL_W'(i % 4), 1'b0);
    end

    // 5. Back-pressure: held beat is scan idx 1; scan_idx now 2
    out_ready = 1'b0;
    #1;
    chk("bp_in_ready", in_ready, 1'b0);
    in_data = {4{32'hDEAD_BEEF}};
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_beat($sformatf("bp%0d", i), CB, 3'd1, 1'b0);
      chk($sformatf("bp%0d_in_ready", i), in_ready, 1'b0);
    end
    in_data = {CD, CC, CB, CA};
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", in_ready, 1'b1);
    tick();
    chk_beat("bp_next", CC, 3'd2, 1'b0);

    // 6. Clear collision. First drain and clear (scan_idx 3 -> 0).
    in_valid = 1'b0; scan_clr = 1'b1;
    tick();
    chk("drain_valid", out_valid, 1'b0);
    scan_clr = 1'b0; in_valid = 1'b1;
    tick();
    chk_beat("pre0", CA, 3'd0, 1'b0);
    // An ext-mode beat must not move scan_idx (stays 1)
    mode = 1'b0; sel = 3'd3;
    tick();
    chk_beat("ext_mid", CD, 3'd3, 1'b0);
    mode = 1'b1;
    tick();
    chk_beat("pre1", CB, 3'd1, 1'b0);
    scan_clr = 1'b1;
    tick();
    chk_beat("clr_beat", CC, 3'd2, 1'b0);
    scan_clr = 1'b0;
    tick();
    chk_beat("after_clr", CA, 3'd0, 1'b0);

    // Reset while stalled
    out_ready = 1'b0;
    tick();
    chk_beat("stall", CA, 3'd0, 1'b0);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_data",  out_data,  32'h0);
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("post_rst_valid", out_valid, 1'b0);
    // scan index restarted from 0 (it was 1 before reset)
    in_valid = 1'b1;
    tick();
    chk_beat("post_rst_scan", CA, 3'd0, 1'b0);
    in_valid = 1'b0;
    tick();
    chk("final_drain", out_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
